inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 4.
REQ-002 SHALL have parameter DATA_W, default 64, entry width: {pc[63:32], inst[31:0]}.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  in  1  synchronous queue discard (branch redirect, exception).
REQ-006 SHALL have ports w_ena_1 / w_ena_2  in  1  write strobes for the fetch-side slots, in program order.
REQ-007 SHALL have ports w_data_1 / w_data_2  in  DATA_W  fetch-side entries.
REQ-008 SHALL have port w_full  out  1  fewer than 2 free slots.
REQ-009 SHALL have ports fifo_r_data_1 / fifo_r_data_2  out  DATA_W  head and head+1 entries.
REQ-010 SHALL have ports fifo_r_data_1_ok / fifo_r_data_2_ok  out  1  corresponding entry valid.
REQ-011 SHALL have ports p_data_1 / p_data_2  in  1  pop strobes from issue.
REQ-012 SHALL have ports stat_full_cycles / stat_empty_cycles  out  32  performance counters.

Function
REQ-013 SHALL hold circular storage with head pointer, tail pointer and count of clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-014 SHALL drive fifo_r_data_1 = mem[head], fifo_r_data_2 = mem[head+1 mod DEPTH] combinationally from registered state.
REQ-015 SHALL drive fifo_r_data_1_ok = (count >= 1), fifo_r_data_2_ok = (count >= 2); a not-ok data port SHALL read 0.
REQ-016 SHALL drive w_full = (count > DEPTH-2), registered-state derived.
REQ-017 SHALL accept writes only when w_full = 0; when w_full = 1 both strobes are dropped in full.
REQ-018 SHALL write w_data_1 at tail and w_data_2 at tail+1 when both strobes set; tail advances by the number written.
REQ-019 SHALL treat w_ena_2 without w_ena_1 as a single write of w_data_2 at tail.
REQ-020 SHALL honour p_data_1 only if fifo_r_data_1_ok, and p_data_2 only if p_data_1 honoured and fifo_r_data_2_ok; p_data_2 alone is ignored.
REQ-021 SHALL advance head by the number of honoured pops.
REQ-022 SHALL update count_next = count + writes - pops in one cycle for simultaneous write and pop.
REQ-023 SHALL make written data visible on the read ports the cycle after the write (no same-cycle bypass, including when empty).
REQ-024 SHALL, on flush, set head = tail = count = 0 next cycle; flush overrides writes and pops of the same cycle.
REQ-025 SHALL NOT modify any entry contents on pop or flush.

Reset
REQ-026 SHALL, on rst, clear head, tail, count and both stat counters; after reset the ok outputs and w_full read 0 and both data outputs read 0.
REQ-027 SHALL give rst priority over flush, writes and pops; storage contents SHALL not need reset.

Configuration
REQ-028 SHALL, with INST_QUEUE_STAT_EN defined, increment stat_full_cycles each cycle w_full = 1 and stat_empty_cycles each cycle count = 0; counters wrap at 2^32 and are not cleared by flush.
REQ-029 SHALL, without INST_QUEUE_STAT_EN, tie both stat outputs to 0 and instantiate no counter registers.

Structure
REQ-030 SHALL take entry-field slices (PC_HI, PC_LO, INST_HI, INST_LO) and the default DEPTH from the shared id_def definitions.
REQ-031 SHALL be a single module without sub-modules; pointer arithmetic is inline.

Verification
REQ-032 Reset, then write {32'hBFC0_0000, 32'h2408_0001} and {32'hBFC0_0004, 32'h2409_0002} together -> next cycle both ok = 1, data matches, count 2.
REQ-033 Fill to 15 of 16 entries -> w_full = 1; dual write then dropped, count stays 15; pop 1 -> w_full = 0 next cycle.
REQ-034 Count = 1, assert p_data_1 and p_data_2 -> only one pop, both ok = 0 next cycle, no underflow.
REQ-035 Head at 15, count 1, dual write plus single pop -> data_1 = mem[0], data_2 = mem[1], count 2.
REQ-036 Count 6, flush with dual write and dual pop same cycle -> next cycle count 0, ok = 0, w_full = 0.
REQ-037 With INST_QUEUE_STAT_EN, 10 empty cycles after reset -> stat_empty_cycles = 10; without it both stat outputs read 0.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared instruction-queue definitions (id_def): default depth, entry
// field slices and an entry-building helper.
// Entry layout: {pc[PC_HI:PC_LO], inst[INST_HI:INST_LO]}.
package inst_queue_pkg;

  localparam int unsigned IQ_DEPTH  = 16;
  localparam int unsigned PC_HI     = 63;
  localparam int unsigned PC_LO     = 32;
  localparam int unsigned INST_HI   = 31;
  localparam int unsigned INST_LO   = 0;
  localparam int unsigned IQ_DATA_W = PC_HI - INST_LO + 1;

  // Pack a pc / instruction pair into one queue entry.
  function automatic logic [IQ_DATA_W-1:0] iq_entry(
    input logic [PC_HI-PC_LO:0]     pc,
    input logic [INST_HI-INST_LO:0] inst
  );
    iq_entry = {pc, inst};
  endfunction

endpackage

// File: rtl/inst_queue.sv
// inst_queue: dual-write / dual-pop circular instruction queue between
// fetch and issue.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : discard all entries (redirect / exception)
//   w_ena_1/2, w_data_1/2 : fetch-side writes, program order
//   w_full              : fewer than two free slots
//   fifo_r_data_1/2(_ok): head and head+1 entries (zero when not valid)
//   p_data_1/2          : issue-side pops
//   stat_full_cycles / stat_empty_cycles : performance counters
// Optional feature macro: INST_QUEUE_STAT_EN enables the counters;
// otherwise both stat outputs are tied to zero.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = IQ_DEPTH,
  parameter int unsigned DATA_W = IQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              w_ena_1,
  input  logic              w_ena_2,
  input  logic [DATA_W-1:0] w_data_1,
  input  logic [DATA_W-1:0] w_data_2,
  output logic              w_full,
  output logic [DATA_W-1:0] fifo_r_data_1,
  output logic [DATA_W-1:0] fifo_r_data_2,
  output logic              fifo_r_data_1_ok,
  output logic              fifo_r_data_2_ok,
  input  logic              p_data_1,
  input  logic              p_data_2,
  output logic [31:0]       stat_full_cycles,
  output logic [31:0]       stat_empty_cycles
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [AW-1:0]     w_head_nx;
  logic [AW-1:0]     w_tail_nx;
  logic [CW-1:0]     w_count_nx;
  logic [AW-1:0]     w_head_1;
  logic [AW-1:0]     w_tail_1;
  logic              w_ok_1;
  logic              w_ok_2;
  logic              w_we_a;
  logic              w_we_b;
  logic [DATA_W-1:0] w_wd_a;
  logic [DATA_W-1:0] w_wd_b;
  logic              w_pop_1;
  logic              w_pop_2;
  logic [1:0]        w_nwr;
  logic [1:0]        w_npop;

  // Status derived from registered state only (no write bypass).
  assign w_ok_1   = (r_count >= CW'(1));
  assign w_ok_2   = (r_count >= CW'(2));
  assign w_full   = (r_count > CW'(DEPTH - 2));
  assign w_head_1 = r_head + AW'(1);
  assign w_tail_1 = r_tail + AW'(1);

  assign fifo_r_data_1    = w_ok_1 ? r_mem[r_head]   : '0;
  assign fifo_r_data_2    = w_ok_2 ? r_mem[w_head_1] : '0;
  assign fifo_r_data_1_ok = w_ok_1;
  assign fifo_r_data_2_ok = w_ok_2;

  // Write slot a lands at tail, slot b at tail+1; a lone w_ena_2 uses slot a.
  // Pop 2 is only honoured behind an honoured pop 1.
  always_comb begin
    w_we_a     = 1'b0;
    w_we_b     = 1'b0;
    w_wd_a     = w_data_1;
    w_wd_b     = w_data_2;
    w_head_nx  = r_head;
    w_tail_nx  = r_tail;
    w_count_nx = r_count;

    if (!rst && !flush && !w_full) begin
      if (w_ena_1) begin
        w_we_a = 1'b1;
        w_we_b = w_ena_2;
      end else if (w_ena_2) begin
        w_we_a = 1'b1;
        w_wd_a = w_data_2;
      end
    end

    w_pop_1 = p_data_1 & w_ok_1;
    w_pop_2 = w_pop_1 & p_data_2 & w_ok_2;
    w_nwr   = {1'b0, w_we_a} + {1'b0, w_we_b};
    w_npop  = {1'b0, w_pop_1} + {1'b0, w_pop_2};

    if (flush) begin
      w_head_nx  = '0;
      w_tail_nx  = '0;
      w_count_nx = '0;
    end else begin
      w_head_nx  = r_head + AW'(w_npop);
      w_tail_nx  = r_tail + AW'(w_nwr);
      w_count_nx = r_count + CW'(w_nwr) - CW'(w_npop);
    end
  end

  // Pointer / occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_nx;
      r_tail  <= w_tail_nx;
      r_count <= w_count_nx;
    end
  end

  // Storage; never cleared, only overwritten by accepted writes.
  always_ff @(posedge clk) begin
    if (w_we_a) r_mem[r_tail]   <= w_wd_a;
    if (w_we_b) r_mem[w_tail_1] <= w_wd_b;
  end

`ifdef INST_QUEUE_STAT_EN
  logic [31:0] r_stat_full;
  logic [31:0] r_stat_empty;

  // Free-running occupancy counters; survive flush, wrap at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_full  <= '0;
      r_stat_empty <= '0;
    end else begin
      if (w_full)             r_stat_full  <= r_stat_full + 32'd1;
      if (r_count == CW'(0))  r_stat_empty <= r_stat_empty + 32'd1;
    end
  end

  assign stat_full_cycles  = r_stat_full;
  assign stat_empty_cycles = r_stat_empty;
`else
  assign stat_full_cycles  = '0;
  assign stat_empty_cycles = '0;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a reference queue model acts as the
// scoreboard (entries pushed when writes are driven, compared at the read
// ports), a hand-written vector table, and directed corner sequences.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, flush, w_ena_1, w_ena_2, p_data_1, p_data_2;
  logic [63:0] w_data_1, w_data_2;
  logic        w_full, ok1, ok2;
  logic [63:0] rd1, rd2;
  logic [31:0] st_full, st_empty;

  int          tests  = 0;
  int          failed = 0;

  logic [63:0] m_q [$];
  logic [31:0] m_sfull, m_sempty;

  inst_queue dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .w_ena_1          (w_ena_1),
    .w_ena_2          (w_ena_2),
    .w_data_1         (w_data_1),
    .w_data_2         (w_data_2),
    .w_full           (w_full),
    .fifo_r_data_1    (rd1),
    .fifo_r_data_2    (rd2),
    .fifo_r_data_1_ok (ok1),
    .fifo_r_data_2_ok (ok2),
    .p_data_1         (p_data_1),
    .p_data_2         (p_data_2),
    .stat_full_cycles (st_full),
    .stat_empty_cycles(st_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every output against the model's current state.
  task automatic check_outputs(input string tag);
    int sz;
    sz = m_q.size();
    chk({tag, "_ok1"},  64'(ok1),    64'(sz >= 1));
    chk({tag, "_ok2"},  64'(ok2),    64'(sz >= 2));
    chk({tag, "_full"}, 64'(w_full), 64'(sz > DEPTH - 2));
    chk({tag, "_rd1"},  rd1, (sz >= 1) ? m_q[0] : 64'h0);
    chk({tag, "_rd2"},  rd2, (sz >= 2) ? m_q[1] : 64'h0);
    chk({tag, "_sfull"},  64'(st_full),  64'(m_sfull));
    chk({tag, "_sempty"}, 64'(st_empty), 64'(m_sempty));
  endtask

  // One clock: drive, confirm no same-cycle effect, update model, clock.
  task automatic step(input logic fl, input logic e1, input logic e2,
                      input logic [63:0] d1, input logic [63:0] d2,
                      input logic p1, input logic p2);
    int   sz;
    logic full, pop1, pop2;
    flush = fl; w_ena_1 = e1; w_ena_2 = e2;
    w_data_1 = d1; w_data_2 = d2; p_data_1 = p1; p_data_2 = p2;
    #1;
    check_outputs("pre");
    sz   = m_q.size();
    full = (sz > DEPTH - 2);
`ifdef INST_QUEUE_STAT_EN
    if (full)    m_sfull  = m_sfull + 32'd1;
    if (sz == 0) m_sempty = m_sempty + 32'd1;
`endif
    if (fl) begin
      m_q.delete();
    end else begin
      pop1 = p1 && (sz >= 1);
      pop2 = pop1 && p2 && (sz >= 2);
      if (pop1) void'(m_q.pop_front());
      if (pop2) void'(m_q.pop_front());
      if (!full) begin
        if (e1) m_q.push_back(d1);
        if (e2) m_q.push_back(d2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        fl, e1, e2;
    logic [63:0] d1, d2;
    logic        p1, p2;
    logic        x_ok1, x_ok2, x_full;
  } vec_t;

  vec_t vecs [9];
  logic [31:0] pc;

  function automatic logic [63:0] ent(input logic [31:0] p);
    return iq_entry(p, 32'h2400_0000 ^ p);
  endfunction

  initial begin
    // Hand-derived vectors, starting from two valid entries.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 64'hDEAD_0001_0000_0001, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 64'hBBBB_0000_0000_0003, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 64'hCCCC_0000_0000_0004, 64'hCCCC_0000_0000_0005, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 64'hEEEE_0000_0000_0006, 64'hEEEE_0000_0000_0007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    m_sfull = '0; m_sempty = '0;
    rst = 1'b1; flush = 1'b0; w_ena_1 = 1'b0; w_ena_2 = 1'b0;
    w_data_1 = '0; w_data_2 = '0; p_data_1 = 1'b0; p_data_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset");

    // Ten empty cycles after reset.
    repeat (10) idle();
`ifdef INST_QUEUE_STAT_EN
    chk("stat_empty_10", 64'(st_empty), 64'd10);
`else
    chk("stat_empty_off", 64'(st_empty), 64'd0);
`endif
    chk("stat_full_0", 64'(st_full), 64'd0);

    // Dual write, visible next cycle.
    step(1'b0, 1'b1, 1'b1, 64'hBFC0_0000_2408_0001, 64'hBFC0_0004_2409_0002, 1'b0, 1'b0);
    chk("dual_ok1", 64'(ok1), 64'd1);
    chk("dual_ok2", 64'(ok2), 64'd1);
    chk("dual_rd1", rd1, 64'hBFC0_0000_2408_0001);
    chk("dual_rd2", rd2, 64'hBFC0_0004_2409_0002);

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].fl, vecs[i].e1, vecs[i].e2, vecs[i].d1, vecs[i].d2, vecs[i].p1, vecs[i].p2);
      chk($sformatf("vec%0d_ok1", i),  64'(ok1),    64'(vecs[i].x_ok1));
      chk($sformatf("vec%0d_ok2", i),  64'(ok2),    64'(vecs[i].x_ok2));
      chk($sformatf("vec%0d_full", i), 64'(w_full), 64'(vecs[i].x_full));
    end

    // Fill to 15: full asserts, dual write dropped, one pop clears full.
    pc = 32'h8000_0000;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b1, ent(pc), ent(pc + 32'd4), 1'b0, 1'b0);
      pc = pc + 32'd8;
    end
    chk("fill14_full", 64'(w_full), 64'd0);
    step(1'b0, 1'b1, 1'b0, ent(pc), 64'h0, 1'b0, 1'b0);
    pc = pc + 32'd4;
    chk("fill15_full", 64'(w_full), 64'd1);
    step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0001, 1'b0, 1'b0);
    chk("drop_full", 64'(w_full), 64'd1);
    step(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
    chk("pop_unfull", 64'(w_full), 64'd0);
    step(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

    // Walk head to 15 with one entry, then wrap with dual write + pop.
    step(1'b0, 1'b1, 1'b0, ent(32'h9000_0000), 64'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++)
      step(1'b0, 1'b1, 1'b0, ent(32'h9000_0000 + 32'(i * 4)), 64'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, ent(32'hA000_0000), ent(32'hA000_0004), 1'b1, 1'b0);
    chk("wrap_rd1", rd1, ent(32'hA000_0000));
    chk("wrap_rd2", rd2, ent(32'hA000_0004));
    chk("wrap_ok2", 64'(ok2), 64'd1);

    // Reach six entries, then flush against simultaneous writes and pops.
    step(1'b0, 1'b1, 1'b1, ent(32'hB000_0000), ent(32'hB000_0004), 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, ent(32'hB000_0008), ent(32'hB000_000C), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, ent(32'hB000_0010), ent(32'hB000_0014), 1'b1, 1'b1);
    chk("flush_ok1", 64'(ok1), 64'd0);
    chk("flush_ok2", 64'(ok2), 64'd0);
    chk("flush_full", 64'(w_full), 64'd0);
    step(1'b0, 1'b0, 1'b1, 64'h0, ent(32'hC000_0000), 1'b0, 1'b0);
    chk("post_flush_rd1", rd1, ent(32'hC000_0000));

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 2) == 0), 1'($urandom));
    end
    idle();
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
